deb_filter: RTL and testbench
=============================

DEB_FILTER -- requirements
Module: deb_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of input synchronizer flops, legal range 2..4.
REQ-002 Parameter STABLE_CYCLES, default 16: consecutive synchronized samples required to accept a new level, legal range 2..65535.
REQ-003 Parameter CNT_WIDTH, default $clog2(STABLE_CYCLES)+1: stability counter width.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in     input  1  raw, possibly bouncing, asynchronous level input.
REQ-007 out    output 1  debounced level, driven directly from a register (no combinational path from in).

Function
REQ-008 in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the synchronized sample s.
REQ-009 Behaviour SHALL be implemented as a 4-state FSM: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
REQ-010 out SHALL be 1 in STABLE_HIGH and PEND_LOW, and 0 in STABLE_LOW and PEND_HIGH.
REQ-011 STABLE_LOW with s=1 SHALL go to PEND_HIGH with cnt=1; with s=0 it SHALL stay, cnt=0.
REQ-012 PEND_HIGH with s=0 SHALL return to STABLE_LOW with cnt=0, so the partial count is discarded.
REQ-013 PEND_HIGH with s=1 and cnt<STABLE_CYCLES-1 SHALL increment cnt; with cnt=STABLE_CYCLES-1 it SHALL go to STABLE_HIGH with cnt=0.
REQ-014 STABLE_HIGH, PEND_LOW SHALL mirror REQ-011..013 with the levels inverted.
REQ-015 out SHALL change on the clock edge that is the STABLE_CYCLES-th consecutive edge with s differing from out.
REQ-016 Latency: if edge k is the first edge sampling a new stable in level, out SHALL update at edge k+SYNC_STAGES-1+STABLE_CYCLES (default k+17).
REQ-017 Any run of fewer than STABLE_CYCLES differing s samples SHALL leave out unchanged.
REQ-018 A glitch shorter than one clock period that no edge samples SHALL have no effect.
REQ-019 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-020 Illegal FSM encodings SHALL recover to STABLE_LOW with cnt=0 on the next edge.

Reset
REQ-021 reset=0 SHALL immediately, with no clock edge needed, clear all synchronizer flops to 0, set state to STABLE_LOW, set cnt to 0 and set out to 0.
REQ-022 Reset asserted during PEND_HIGH or PEND_LOW SHALL abort the pending transition; after release, qualification restarts from zero.
REQ-023 After reset release with in=1, out SHALL rise per REQ-016 and not earlier.

Verification (defaults, 20 ns clock)
REQ-024 reset=0 for 1000 ns with in=0 -> out=0 throughout; release, in=0 for 1000 ns -> out stays 0.
REQ-025 in=1 for 10 cycles (200 ns), then 0 -> out stays 0 and FSM returns to STABLE_LOW.
REQ-026 10 ns low glitch not sampled, then in=1 for 30 cycles -> out rises exactly 17 edges after the first edge sampling 1.
REQ-027 With out=1, in=0 for 2 cycles (40 ns), then 1 for 10 cycles -> out stays 1.
REQ-028 With out=1, in=0 held -> out falls exactly 17 edges after the first edge sampling 0.
REQ-029 Assert reset mid-way through a PEND_HIGH count (cnt=8) -> out=0, cnt=0 asynchronously; after release, the full 17-edge latency is required again.

Source files
------------

// File: rtl/deb_filter.sv
// Debouncer: synchronizes a bouncing level input and only accepts a new level
// after STABLE_CYCLES consecutive matching samples. Ports: clock, reset (async, active-low), in (raw), out (registered).
module deb_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES) + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic                   out_q, out_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], in};
  assign s      = sync_q[SYNC_STAGES-1];
  assign out    = out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = PEND_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = PEND_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // out follows the next state so it toggles on the qualifying edge itself
  always_comb begin
    out_d = 1'b0;
    unique case (1'b1)
      (state_d == STABLE_HIGH): out_d = 1'b1;
      (state_d == PEND_LOW):    out_d = 1'b1;
      default:                  out_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_deb_filter.sv
// Bench for deb_filter: run-length reference model feeds a scoreboard queue,
// plus directed latency, glitch and reset-abort scenarios.
module tb_deb_filter;

  localparam int STABLE = 16;
  localparam int LAT    = 17;

  logic clk;
  logic rst_n;
  logic din;
  logic dout;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;

  logic       exp_q[$];
  logic [1:0] m_sync;
  logic       m_out;
  int         m_run;

  deb_filter dut (
    .clock(clk),
    .reset(rst_n),
    .in   (din),
    .out  (dout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // reference: out toggles once STABLE consecutive synced samples differ
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync = 2'b00;
      m_out  = 1'b0;
      m_run  = 0;
      exp_q.delete();
    end else begin
      if (m_sync[1] != m_out) m_run++;
      else m_run = 0;
      if (m_run == STABLE) begin
        m_out = ~m_out;
        m_run = 0;
      end
      m_sync = {m_sync[0], din};
      edge_n++;
      exp_q.push_back(m_out);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) chk("rst_out", 32'(dout), 0);
    else if (exp_q.size() > 0) chk("sb_out", 32'(dout), 32'(exp_q.pop_front()));
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  // edge on which out reaches lvl, compared with k + LAT
  task automatic meas(string tag, logic lvl, int k);
    int found;
    found = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dout === lvl) begin
        found = edge_n;
        break;
      end
    end
    chk(tag, 32'(found), 32'(k + LAT));
  endtask

  initial begin
    int k;
    int hit;
    rst_n = 1'b0;
    din   = 1'b0;
    #1;
    chk("rst_imm_out", 32'(dout), 0);
    chk("rst_imm_cnt", 32'(dut.cnt_q), 0);
    #999;
    chk("rst_hold_out", 32'(dout), 0);
    step(1);
    rst_n = 1'b1;
    step(50);
    chk("idle_low", 32'(dout), 0);

    // short high pulse is rejected
    din = 1'b1;
    step(10);
    din = 1'b0;
    step(20);
    chk("short_out", 32'(dout), 0);
    chk("short_cnt", 32'(dut.cnt_q), 0);

    // unsampled low glitch then a real rise
    din = 1'b1;
    k = edge_n + 1;
    #2 din = 1'b0;
    #10 din = 1'b1;
    meas("rise_lat", 1'b1, k);
    step(12);
    chk("high_hold", 32'(dout), 1);

    // short low dip is rejected
    din = 1'b0;
    step(2);
    din = 1'b1;
    step(10);
    chk("dip_out", 32'(dout), 1);
    step(5);

    // real fall
    din = 1'b0;
    k = edge_n + 1;
    meas("fall_lat", 1'b0, k);
    step(5);

    // random bouncing, covered by the scoreboard
    for (int i = 0; i < 40; i++) begin
      din = 1'($urandom_range(0, 1));
      step($urandom_range(1, 24));
    end
    din = 1'b0;
    step(25);
    chk("rand_settle", 32'(dout), 0);

    // reset in the middle of a pending rise
    din = 1'b1;
    hit = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dut.cnt_q == 8) begin
        hit = 1;
        break;
      end
    end
    chk("cnt8_seen", 32'(hit), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_out", 32'(dout), 0);
    chk("abort_cnt", 32'(dut.cnt_q), 0);
    step(3);
    rst_n = 1'b1;
    k = edge_n + 1;
    meas("rerise_lat", 1'b1, k);
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
